// File: rtl/hilo_mul_ctrl.sv
// rtl/hilo_mul_ctrl.sv - MIPS HI/LO sequencing stage wrapped around a 2-stage multiply core.
// Accepts MULT/MADD/MSUB/MTHI/MTLO, writes HI/LO two cycles after a multiply issues.

module mul (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        mul_signed,
  output logic [63:0] result
);

  logic [31:0] x_q, x_d;
  logic [31:0] y_q, y_d;
  logic        sgn_q, sgn_d;
  logic [63:0] prod_q, prod_d;
  logic [63:0] x_ext, y_ext;

  // Operands are sampled every edge; the product lands one edge later.
  always_comb begin
    x_d    = x;
    y_d    = y;
    sgn_d  = mul_signed;
    x_ext  = {{32{sgn_q & x_q[31]}}, x_q};
    y_ext  = {{32{sgn_q & y_q[31]}}, y_q};
    prod_d = x_ext * y_ext;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      x_q    <= '0;
      y_q    <= '0;
      sgn_q  <= 1'b0;
      prod_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      sgn_q  <= sgn_d;
      prod_q <= prod_d;
    end
  end

  assign result = prod_q;

endmodule

module hilo_mul_ctrl #(
  parameter bit ACC_EN = 1'b1
) (
  input  logic        mul_clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    M1   = 2'd1,
    M2   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CLS_MULT = 2'd0,
    CLS_MADD = 2'd1,
    CLS_MSUB = 2'd2
  } cls_t;

  state_t      state_q, state_d;
  cls_t        cls_q, cls_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] product;
  logic [63:0] acc;
  logic [63:0] wb;
  logic        accept;

  mul u_mul (
    .clk        (mul_clk),
    .resetn     (~reset),
    .x          (req_a),
    .y          (req_b),
    .mul_signed (~req_op[0]),
    .result     (product)
  );

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy      = 1'b0;
    done      = 1'b0;
    req_ready = (state_q == IDLE) && !flush;
    accept    = req_valid && req_ready;
    acc       = {hi_q, lo_q};
    wb        = product;

    case (cls_q)
      CLS_MADD: wb = acc + product;
      CLS_MSUB: wb = acc - product;
      default:  wb = product;
    endcase

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_op[2:1] == 2'b11) begin
            if (req_op[0]) lo_d = req_a;
            else           hi_d = req_a;
          end else begin
            state_d = M1;
            // Without the accumulator, MADD/MSUB encodings degrade to plain multiplies.
            if (ACC_EN && req_op[2:1] == 2'b01)      cls_d = CLS_MADD;
            else if (ACC_EN && req_op[2:1] == 2'b10) cls_d = CLS_MSUB;
            else                                     cls_d = CLS_MULT;
          end
        end
      end
      M1: begin
        busy    = 1'b1;
        state_d = flush ? IDLE : M2;
      end
      M2: begin
        busy    = 1'b1;
        state_d = IDLE;
        if (!flush) begin
          done = 1'b1;
          hi_d = wb[63:32];
          lo_d = wb[31:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mul_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cls_q   <= CLS_MULT;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// tb/tb_hilo_mul_ctrl.sv - directed self-checking bench for hilo_mul_ctrl.
// A second instance with ACC_EN=0 shares the stimulus.

module tb_hilo_mul_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        flush;
  logic        req_ready, busy, done;
  logic [31:0] hi, lo;
  logic        req_ready2, busy2, done2;
  logic [31:0] hi2, lo2;

  int checks = 0;
  int failures = 0;

  localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_MADD = 3'b010,
                         OP_MADDU = 3'b011, OP_MSUB = 3'b100, OP_MSUBU = 3'b101,
                         OP_MTHI = 3'b110, OP_MTLO = 3'b111;

  always #5 clk = ~clk;

  hilo_mul_ctrl #(.ACC_EN(1'b1)) dut (
    .mul_clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  hilo_mul_ctrl #(.ACC_EN(1'b0)) dut_noacc (
    .mul_clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready2),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .flush(flush),
    .busy(busy2), .done(done2), .hi(hi2), .lo(lo2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic move_to(input logic [2:0] op, input logic [31:0] d);
    req_valid = 1'b1; req_op = op; req_a = d; req_b = 32'h0;
    step();
    req_valid = 1'b0;
  endtask

  task automatic run_mul(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    step();
    req_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_op = 3'b0; req_a = '0; req_b = '0; flush = 1'b0;
    step();
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      failures++; $display("FAIL reset_hilo hi=%h lo=%h want 0/0", hi, lo);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL reset_flags busy=%b done=%b want 0/0", busy, done);
    end
    reset = 1'b0;
    step();
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready req_ready=%b want 1", req_ready);
    end
  endtask

  task automatic test_mult();
    req_valid = 1'b1; req_op = OP_MULT; req_a = 32'hFFFFFFFD; req_b = 32'd5;
    step();
    req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || req_ready !== 1'b0) begin
      failures++; $display("FAIL mult_m1 busy=%b done=%b ready=%b want 1/0/0", busy, done, req_ready);
    end
    step();
    checks++;
    if (busy !== 1'b1 || done !== 1'b1) begin
      failures++; $display("FAIL mult_m2 busy=%b done=%b want 1/1", busy, done);
    end
    step();
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
      failures++; $display("FAIL mult_neg hi=%h lo=%h want ffffffff/fffffff1", hi, lo);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL mult_after busy=%b done=%b ready=%b want 0/0/1", busy, done, req_ready);
    end
    run_mul(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checks++;
    if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      failures++; $display("FAIL multu_max hi=%h lo=%h want fffffffe/00000001", hi, lo);
    end
    run_mul(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checks++;
    if (hi !== 32'h0 || lo !== 32'h1) begin
      failures++; $display("FAIL mult_m1m1 hi=%h lo=%h want 0/1", hi, lo);
    end
  endtask

  task automatic test_accumulate();
    move_to(OP_MTLO, 32'd1);
    move_to(OP_MTHI, 32'd0);
    checks++;
    if (hi !== 32'h0 || lo !== 32'h1 || busy !== 1'b0) begin
      failures++; $display("FAIL mthi_mtlo hi=%h lo=%h busy=%b want 0/1/0", hi, lo, busy);
    end
    run_mul(OP_MADD, 32'd2, 32'd3);
    checks++;
    if (hi !== 32'h0 || lo !== 32'h7) begin
      failures++; $display("FAIL madd hi=%h lo=%h want 0/7", hi, lo);
    end
    checks++;
    if (hi2 !== 32'h0 || lo2 !== 32'h6) begin
      failures++; $display("FAIL noacc_madd hi=%h lo=%h want 0/6", hi2, lo2);
    end
    run_mul(OP_MSUBU, 32'h10, 32'h1);
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF7) begin
      failures++; $display("FAIL msubu hi=%h lo=%h want ffffffff/fffffff7", hi, lo);
    end
    run_mul(OP_MADDU, 32'd9, 32'd1);
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      failures++; $display("FAIL maddu_wrap hi=%h lo=%h want 0/0", hi, lo);
    end
    move_to(OP_MTHI, 32'd0);
    move_to(OP_MTLO, 32'd10);
    run_mul(OP_MSUB, 32'hFFFFFFFE, 32'd3);
    checks++;
    if (hi !== 32'h0 || lo !== 32'd16) begin
      failures++; $display("FAIL msub_neg hi=%h lo=%h want 0/10", hi, lo);
    end
  endtask

  task automatic test_flush();
    move_to(OP_MTHI, 32'h11);
    move_to(OP_MTLO, 32'h22);
    for (int stage = 0; stage < 2; stage++) begin
      req_valid = 1'b1; req_op = OP_MULT; req_a = 32'd7; req_b = 32'd7;
      step();
      req_valid = 1'b0;
      if (stage == 1) step();
      flush = 1'b1;
      #1;
      checks++;
      if (done !== 1'b0) begin
        failures++; $display("FAIL flush_done stage=%0d done=%b want 0", stage, done);
      end
      step();
      flush = 1'b0;
      #1;
      checks++;
      if (hi !== 32'h11 || lo !== 32'h22 || busy !== 1'b0 || req_ready !== 1'b1) begin
        failures++;
        $display("FAIL flush_state stage=%0d hi=%h lo=%h busy=%b ready=%b want 11/22/0/1",
                 stage, hi, lo, busy, req_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_op = OP_MULT; req_a = 32'd2; req_b = 32'd3;
    step();
    req_a = 32'd4; req_b = 32'd5;
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL b2b_m1 ready=%b busy=%b want 0/1", req_ready, busy);
    end
    step();
    checks++;
    if (req_ready !== 1'b0 || done !== 1'b1) begin
      failures++; $display("FAIL b2b_m2 ready=%b done=%b want 0/1", req_ready, done);
    end
    step();
    checks++;
    if (lo !== 32'd6 || busy !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_first lo=%h busy=%b ready=%b want 6/0/1", lo, busy, req_ready);
    end
    step();
    req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL b2b_second_accept busy=%b want 1", busy);
    end
    step();
    step();
    checks++;
    if (hi !== 32'h0 || lo !== 32'd20 || busy !== 1'b0) begin
      failures++; $display("FAIL b2b_second hi=%h lo=%h busy=%b want 0/14/0", hi, lo, busy);
    end
    flush = 1'b1; req_valid = 1'b1; req_op = OP_MTLO; req_a = 32'hABC;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++; $display("FAIL flush_idle_ready ready=%b want 0", req_ready);
    end
    step();
    req_op = OP_MULT; req_a = 32'd3; req_b = 32'd3;
    step();
    req_valid = 1'b0; flush = 1'b0;
    checks++;
    if (lo !== 32'd20 || busy !== 1'b0) begin
      failures++; $display("FAIL flush_idle_accept lo=%h busy=%b want 14/0", lo, busy);
    end
  endtask

  task automatic test_reset_mid_op();
    move_to(OP_MTHI, 32'h5);
    move_to(OP_MTLO, 32'h6);
    req_valid = 1'b1; req_op = OP_MULT; req_a = 32'd3; req_b = 32'd3;
    step();
    req_valid = 1'b0;
    step();
    reset = 1'b1;
    #1;
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid hi=%h lo=%h busy=%b done=%b want 0/0/0/0", hi, lo, busy, done);
    end
    step();
    reset = 1'b0;
    step();
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_after hi=%h lo=%h ready=%b busy=%b want 0/0/1/0", hi, lo, req_ready, busy);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_accumulate();
    test_flush();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hilo_mul_ctrl.md
Name: hilo_mul_ctrl

Overview:
- Sequencing and architectural-state stage placed directly downstream of the 2-stage `mul` core; owns the MIPS HI/LO registers.
- Accepts one multiply-class op per transaction from the EX stage and drives `mul` (instantiated inside this block).
- Consumes `mul`'s 64-bit product two cycles after issue and writes HI/LO, optionally accumulating (MADD/MSUB).
- Exposes busy/done so the pipeline interlocks MFHI/MFLO and later HI/LO users.

Parameters:
- ACC_EN, 1, when 0 the MADD/MADDU/MSUB/MSUBU encodings behave as MULT/MULTU (no accumulate adder).

Ports:
- mul_clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  EX stage presents an op.
- req_ready  out  1  block can accept an op this cycle.
- req_op  in  3  000 MULT, 001 MULTU, 010 MADD, 011 MADDU, 100 MSUB, 101 MSUBU, 110 MTHI, 111 MTLO.
- req_a  in  32  rs operand; also the MTHI/MTLO data.
- req_b  in  32  rt operand.
- flush  in  1  exception/eret cancel of any in-flight op.
- busy  out  1  multiply in flight; HI/LO not final.
- done  out  1  one-cycle pulse in the cycle before the HI/LO write.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset, asynchronous, any state: state=IDLE, hi=0, lo=0, busy=0, done=0, latched op cleared. An in-flight op is discarded. req_ready is high in the first cycle after reset deasserts.
- `mul` hookup:
  - x=req_a, y=req_b; mul_signed = ~req_op[0].
  - `mul` resetn is tied to ~reset.
  - Operands are not held by this block: `mul` captures them at the accept edge.
- FSM states: IDLE, M1, M2.
- req_ready = (state==IDLE) & ~flush. An op is accepted at edge E0 when req_valid & req_ready.
- IDLE, accepted MTHI: hi<=req_a at E0; MTLO: lo<=req_a at E0. State stays IDLE, busy stays 0.
- IDLE, accepted multiply op: latch op class (mult/madd/msub) and go to M1 at E0.
  - busy=1 in M1 and M2.
- M1 -> M2 unconditionally (unless flush). `mul` result becomes valid during M2.
- M2, result write at edge E2, then return to IDLE:
  - done=1 during M2.
  - MULT/MULTU: {hi,lo} <= result.
  - MADD/MADDU: {hi,lo} <= {hi,lo} + result.
  - MSUB/MSUBU: {hi,lo} <= {hi,lo} - result.
- Latency and throughput:
  - Accumulate arithmetic is 64-bit modulo 2^64, no overflow flag; signedness only affects the product.
  - Latency is accept-to-HI/LO-visible = 3 edges (E0 accept, HI/LO updated at E2, visible the cycle after).
  - Throughput is one multiply per 3 cycles; the next accept is possible at the edge after E2.
- Flush:
  - Flush in M1 or M2 returns to IDLE at the next edge; no HI/LO write; done is forced 0 that cycle.
  - Flush in IDLE blocks acceptance, including MTHI/MTLO.
  - Flush together with req_valid: flush wins, nothing accepted.
- req_valid while busy is ignored (req_ready=0); the requester holds the request.
- hi/lo outputs are the registers directly. No bypass of the pending product; consumers stall on busy.
- Reset mid-op overrides flush and all writes.

Test Plan:
- MULT req_a=0xFFFFFFFD, req_b=5 -> done pulses 2 cycles after accept; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy low afterwards.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT with the same operands -> hi=0, lo=1.
- MTLO 1, MTHI 0, then MADD 2x3 -> lo=7, hi=0. Then MSUBU 0x10x1 -> lo=0xFFFFFFF7, hi=0xFFFFFFFF. Then MADDU 9x1 -> hi=0, lo=0 (wrap).
- MULT 7x7 issued with hi/lo=0x11/0x22; flush asserted in M1 (repeat in M2) -> no done, hi/lo stay 0x11/0x22, req_ready high next cycle.
- Back-to-back: req_valid held high with two MULTs -> second accepted exactly one cycle after the first's write edge; req_ready=0 during M1/M2. Flush with req_valid in IDLE -> nothing accepted.
- Assert reset asynchronously mid-M2 with hi/lo=0x5/0x6 -> hi=lo=0 immediately, busy=0, no done. ACC_EN=0: MADD 2x3 over hi/lo=0/1 -> lo=6.
